// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file.
//   DATA_W_DEF / ADDR_W_DEF : default data and address widths
//   nregs()                 : number of registers addressed by an ADDR_W-bit address
//   reg_addr_t / reg_data_t : address and data types at the default widths
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 3;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

    function automatic int nregs(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy scoreboard for the register file.
// One busy bit per register.
// - An issue marks its destination register busy.
// - A write (completion) clears the busy bit of its register.
// - A flush clears every busy bit.
// - Reset clears every busy bit.
//
// Ports
//   clk, rst  : clock, synchronous active-high reset
//   ia, ie    : issue destination address and issue enable
//   wa, we    : completing write address and write enable
//   flush     : clear all busy bits
//   busy_vec  : registered busy bits, bit i = register i
//   issue_ok  : issue of ia is accepted this cycle
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter bit ZERO_R0 = 1'b1,
    localparam int NREGS  = nregs(ADDR_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ia,
    input  logic              ie,
    input  logic [ADDR_W-1:0] wa,
    input  logic              we,
    input  logic              flush,
    output logic [NREGS-1:0]  busy_vec,
    output logic              issue_ok
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // A write completing into ia this cycle frees the slot for the new issue.
    assign issue_ok = !busy_q[ia] || (we && (wa == ia)) || (ZERO_R0 && (ia == '0));

    // Order matters: the issue set follows the completion clear, so a
    // same-register write+issue leaves the new writer pending.
    // Flush is applied last so that it beats any issue.
    always_comb begin
        busy_d = busy_q;
        if (we) begin
            busy_d[wa] = 1'b0;
        end
        if (ie && issue_ok) begin
            busy_d[ia] = 1'b1;
        end
        if (ZERO_R0) begin
            busy_d[0] = 1'b0;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with a busy scoreboard.
// - Two combinational read ports.
// - One synchronous write port.
// - Optional hardwired zero register.
// - Optional write-to-read bypass.
// - Issue/complete busy tracking for hazard detection.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   ra1/ra2          : read addresses
//   rd1/rd2          : read data (combinational)
//   rbusy1/rbusy2    : read register has a pending writer
//   wa, wd, we       : write port; a write also completes the pending writer
//   ia, ie, issue_ok : issue destination, issue enable, issue accepted
//   flush            : clear all busy bits
//   busy_vec         : busy bit per register
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1,
    localparam int NREGS  = nregs(ADDR_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rbusy1,
    output logic              rbusy2,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              we,
    input  logic [ADDR_W-1:0] ia,
    input  logic              ie,
    output logic              issue_ok,
    input  logic              flush,
    output logic [NREGS-1:0]  busy_vec
);

    logic [DATA_W-1:0] mem_q [NREGS];
    logic              wr_zero;
    logic              wr_eff;
    logic              fwd1;
    logic              fwd2;

    assign wr_zero = ZERO_R0 && (wa == '0);
    assign wr_eff  = we && !wr_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_eff) begin
            mem_q[wa] <= wd;
        end
    end

    assign fwd1 = BYPASS && wr_eff && (wa == ra1);
    assign fwd2 = BYPASS && wr_eff && (wa == ra2);

    always_comb begin
        rd1 = mem_q[ra1];
        if (fwd1) begin
            rd1 = wd;
        end
        if (ZERO_R0 && (ra1 == '0)) begin
            rd1 = '0;
        end
    end

    always_comb begin
        rd2 = mem_q[ra2];
        if (fwd2) begin
            rd2 = wd;
        end
        if (ZERO_R0 && (ra2 == '0)) begin
            rd2 = '0;
        end
    end

    // A register whose value is being forwarded this cycle is not reported busy.
    assign rbusy1 = busy_vec[ra1] && !fwd1 && !(ZERO_R0 && (ra1 == '0));
    assign rbusy2 = busy_vec[ra2] && !fwd2 && !(ZERO_R0 && (ra2 == '0));

    reg_scoreboard #(
        .ADDR_W  (ADDR_W),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .ia       (ia),
        .ie       (ie),
        .wa       (wa),
        .we       (we),
        .flush    (flush),
        .busy_vec (busy_vec),
        .issue_ok (issue_ok)
    );

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ra1, ra2, wa, ia;
    logic [31:0] rd1, rd2, wd;
    logic        rbusy1, rbusy2, we, ie, issue_ok, flush;
    logic [7:0]  busy_vec;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: register contents and pending-writer flags.
    logic [31:0] m_mem  [8];
    bit          m_busy [8];

    regfile_sb dut (
        .clk(clk), .rst(rst),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .rbusy1(rbusy1), .rbusy2(rbusy2),
        .wa(wa), .wd(wd), .we(we),
        .ia(ia), .ie(ie), .issue_ok(issue_ok),
        .flush(flush), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        if (a == 0) return 32'h0;
        if (we && wa == a) return wd;
        return m_mem[a];
    endfunction

    function automatic logic exp_rbusy(input logic [2:0] a);
        if (a == 0) return 1'b0;
        if (we && wa == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic exp_ok();
        return (ia == 0) || !m_busy[ia] || (we && wa == ia);
    endfunction

    function automatic logic [7:0] exp_bv();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic idle();
        rst = 0; we = 0; ie = 0; flush = 0;
        wa = 0; wd = 0; ia = 0; ra1 = 0; ra2 = 0;
    endtask

    // Compare all outputs with the model, then clock once and advance the model.
    task automatic cycle();
        bit ok;
        #1;
        chk("rd1", rd1, exp_rd(ra1));
        chk("rd2", rd2, exp_rd(ra2));
        chk("rbusy1", rbusy1, exp_rbusy(ra1));
        chk("rbusy2", rbusy2, exp_rbusy(ra2));
        chk("issue_ok", issue_ok, exp_ok());
        chk("busy_vec", busy_vec, exp_bv());
        ok = exp_ok();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 8; i++) begin m_mem[i] = 0; m_busy[i] = 0; end
        end else begin
            if (we && wa != 0) m_mem[wa] = wd;
            if (we) m_busy[wa] = 0;
            if (ie && ok && ia != 0) m_busy[ia] = 1;
            if (flush) for (int i = 0; i < 8; i++) m_busy[i] = 0;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin m_mem[i] = 0; m_busy[i] = 0; end
        idle();
        rst = 1;
        @(posedge clk); #1;
        idle();

        // 1: fill 1..7, reset, everything reads back zero
        for (int i = 1; i < 8; i++) begin
            we = 1; wa = 3'(i); wd = 32'h1000_0000 + i; cycle();
        end
        idle(); ia = 3; ie = 1; cycle();
        idle(); rst = 1; we = 1; wa = 4; wd = 32'hdead; cycle();
        idle();
        for (int i = 0; i < 8; i += 2) begin
            ra1 = 3'(i); ra2 = 3'(i + 1); #1;
            chk("rst_rd1", rd1, 0);
            chk("rst_rd2", rd2, 0);
        end
        chk("rst_busy", busy_vec, 0);
        chk("rst_ok", issue_ok, 1);

        // 2: bypass and write-through
        idle(); we = 1; wa = 3; wd = 32'haaaaaaaa; ra2 = 3; #1;
        chk("byp_rd2", rd2, 32'haaaaaaaa);
        cycle();
        idle(); ra1 = 3; #1;
        chk("wr_rd1", rd1, 32'haaaaaaaa);
        cycle();

        // 3: zero register ignores writes and issues
        idle(); we = 1; wa = 0; wd = 32'hffffffff; ie = 1; ia = 0; ra1 = 0; #1;
        chk("r0_rd1", rd1, 0);
        chk("r0_ok", issue_ok, 1);
        cycle();
        idle(); #1;
        chk("r0_busy", busy_vec[0], 0);
        chk("r0_rd1_after", rd1, 0);

        // 4: issue, hazard, completion with bypass
        idle(); ie = 1; ia = 5; cycle();
        idle(); #1;
        chk("iss_bv", busy_vec, 8'h20);
        ia = 5; ra1 = 5; #1;
        chk("iss_ok0", issue_ok, 0);
        chk("iss_rbusy1", rbusy1, 1);
        cycle();
        idle(); ra1 = 5; we = 1; wa = 5; wd = 32'h12345678; #1;
        chk("cmp_rbusy1", rbusy1, 0);
        chk("cmp_rd1", rd1, 32'h12345678);
        cycle();
        idle(); #1;
        chk("cmp_bv", busy_vec, 0);

        // 5: write+issue to the same busy register
        idle(); ie = 1; ia = 6; cycle();
        idle(); we = 1; wa = 6; wd = 32'h87654321; ie = 1; ia = 6; #1;
        chk("wi_ok", issue_ok, 1);
        cycle();
        idle(); ra1 = 6; #1;
        chk("wi_mem6", rd1, 32'h87654321);
        chk("wi_busy6", busy_vec[6], 1);
        cycle();

        // 6: flush beats issue, write still lands; reset beats write
        idle(); ie = 1; ia = 2; cycle();
        idle(); ie = 1; ia = 4; cycle();
        idle(); flush = 1; ie = 1; ia = 7; we = 1; wa = 1; wd = 32'h11111111; cycle();
        idle(); ra1 = 1; #1;
        chk("fl_bv", busy_vec, 0);
        chk("fl_mem1", rd1, 32'h11111111);
        cycle();
        idle(); ie = 1; ia = 3; cycle();
        idle(); rst = 1; we = 1; wa = 2; wd = 32'hcafef00d; cycle();
        idle(); ra1 = 2; #1;
        chk("rst_mem2", rd1, 0);
        chk("rst_bv", busy_vec, 0);
        cycle();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 19) == 0);
            we    = ($urandom_range(0, 2) == 0);
            ie    = ($urandom_range(0, 1) == 0);
            wa    = 3'($urandom);
            ia    = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom);
            ra1   = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom);
            ra2   = ($urandom_range(0, 3) == 0) ? ia : 3'($urandom);
            wd    = $urandom;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
